// File: rtl/register_writeback_arbiter_if.sv
// ALU and load-unit writeback channels into the register writeback arbiter.
// Producers use the master modport; the arbiter uses the slave modport.
interface register_writeback_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 32
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_addr;
    logic [REG_WIDTH-1:0]  alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/register_writeback_arbiter.sv
// Two-channel writeback arbiter: buffers ALU and load results in a FIFO,
// drains one per cycle to the register file and forwards pending values.
module register_writeback_arbiter #(
    parameter int REG_WIDTH       = 32,
    parameter int NUM_REGS        = 32,
    parameter int ADDR_WIDTH      = $clog2(NUM_REGS),
    parameter bit REG_ZERO_GROUND = 1'b1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    register_writeback_arbiter_if.slave wb,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [REG_WIDTH-1:0]    write_data,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr_0,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr_1,
    output logic                    fwd_hit_0,
    output logic                    fwd_hit_1,
    output logic [REG_WIDTH-1:0]    fwd_data_0,
    output logic [REG_WIDTH-1:0]    fwd_data_1,
    output logic [$clog2(FIFO_DEPTH):0] pending_count,
    output logic                    idle
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  data;
    } entry_t;

    entry_t        fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] second_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] push_n;
    logic          prio_mem;
    logic          alu_acc;
    logic          mem_acc;
    logic          alu_push;
    logic          mem_push;
    logic          first_push;
    logic          second_push;
    logic          toggle;
    logic          pop;
    entry_t        alu_e;
    entry_t        mem_e;
    entry_t        first_e;
    entry_t        second_e;

    assign free = DEPTH_C - count;

    // Readiness comes from occupancy only; the last free slot goes to priority.
    always_comb begin
        wb.alu_ready = 1'b0;
        wb.mem_ready = 1'b0;
        if (rst_n) begin
            if (free >= CW'(2)) begin
                wb.alu_ready = 1'b1;
                wb.mem_ready = 1'b1;
            end else if (free == CW'(1)) begin
                wb.alu_ready = ~prio_mem;
                wb.mem_ready = prio_mem;
            end
        end
    end

    assign alu_acc  = wb.alu_valid & wb.alu_ready;
    assign mem_acc  = wb.mem_valid & wb.mem_ready;
    assign alu_push = alu_acc & ~(REG_ZERO_GROUND && wb.alu_addr == '0);
    assign mem_push = mem_acc & ~(REG_ZERO_GROUND && wb.mem_addr == '0);
    assign alu_e    = '{addr: wb.alu_addr, data: wb.alu_data};
    assign mem_e    = '{addr: wb.mem_addr, data: wb.mem_data};

    always_comb begin
        first_push  = alu_push;
        first_e     = alu_e;
        second_push = mem_push;
        second_e    = mem_e;
        if (prio_mem) begin
            first_push  = mem_push;
            first_e     = mem_e;
            second_push = alu_push;
            second_e    = alu_e;
        end
    end

    assign second_ptr = first_push ? wr_ptr + PW'(1) : wr_ptr;
    assign push_n     = CW'(first_push) + CW'(second_push);
    assign pop        = (count != '0);
    assign toggle     = prio_mem ? (mem_acc & wb.alu_valid)
                                 : (alu_acc & wb.mem_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            prio_mem     <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            if (pop) begin
                write_enable <= 1'b1;
                write_addr   <= fifo_q[rd_ptr].addr;
                write_data   <= fifo_q[rd_ptr].data;
                rd_ptr       <= rd_ptr + PW'(1);
            end else begin
                write_enable <= 1'b0;
            end
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + push_n - CW'(pop);
            if (toggle) prio_mem <= ~prio_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (first_push)  fifo_q[wr_ptr]     <= first_e;
            if (second_push) fifo_q[second_ptr] <= second_e;
        end
    end

    // Later FIFO slots are younger, so a later match overrides an earlier one.
    function automatic logic [REG_WIDTH:0] lookup(
        input logic [ADDR_WIDTH-1:0] a
    );
        logic                 hit;
        logic [REG_WIDTH-1:0] data;
        logic [PW-1:0]        idx;
        hit  = write_enable && (write_addr == a);
        data = hit ? write_data : '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && fifo_q[idx].addr == a) begin
                hit  = 1'b1;
                data = fifo_q[idx].data;
            end
        end
        if (REG_ZERO_GROUND && a == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    assign {fwd_hit_0, fwd_data_0} = lookup(fwd_addr_0);
    assign {fwd_hit_1, fwd_data_1} = lookup(fwd_addr_1);

    assign pending_count = count;
    assign idle          = (count == '0) & ~write_enable;
endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Directed and randomized bench for register_writeback_arbiter against a
// queue-based model of the buffered writeback behaviour.
module tb_register_writeback_arbiter;
    localparam int AW = 5;
    localparam int RW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [RW-1:0] write_data;
    logic [AW-1:0] fwd_addr_0;
    logic [AW-1:0] fwd_addr_1;
    logic          fwd_hit_0;
    logic          fwd_hit_1;
    logic [RW-1:0] fwd_data_0;
    logic [RW-1:0] fwd_data_1;
    logic [2:0]    pending_count;
    logic          idle;

    always #5 clk = ~clk;

    register_writeback_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) wb();

    register_writeback_arbiter #(
        .REG_WIDTH(RW), .NUM_REGS(32), .ADDR_WIDTH(AW),
        .REG_ZERO_GROUND(1'b1), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data),
        .fwd_addr_0(fwd_addr_0), .fwd_addr_1(fwd_addr_1),
        .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
        .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1),
        .pending_count(pending_count), .idle(idle)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [RW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [RW-1:0] m_wd;
    bit            m_prio_mem;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_alu_ready();
        int f = D - q.size();
        return (f >= 2) || (f == 1 && !m_prio_mem);
    endfunction

    function automatic bit m_mem_ready();
        int f = D - q.size();
        return (f >= 2) || (f == 1 && m_prio_mem);
    endfunction

    task automatic m_fwd(input logic [AW-1:0] a, output logic hit,
                         output logic [RW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (a != 0) begin
            if (m_we && m_wa == a) begin
                hit  = 1'b1;
                data = m_wd;
            end
            foreach (q[i]) if (q[i].a == a) begin
                hit  = 1'b1;
                data = q[i].d;
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we       = 1'b0;
        m_wa       = '0;
        m_wd       = '0;
        m_prio_mem = 1'b0;
    endtask

    // Applies one clock edge of the rules to the model using current inputs.
    task automatic model_edge();
        bit   ar, mr, aacc, macc, tog;
        ent_t ae, me;
        ar   = m_alu_ready();
        mr   = m_mem_ready();
        aacc = wb.alu_valid && ar;
        macc = wb.mem_valid && mr;
        tog  = m_prio_mem ? (macc && wb.alu_valid) : (aacc && wb.mem_valid);
        ae   = '{a: wb.alu_addr, d: wb.alu_data};
        me   = '{a: wb.mem_addr, d: wb.mem_data};
        if (q.size() > 0) begin
            m_we = 1'b1;
            m_wa = q[0].a;
            m_wd = q[0].d;
            void'(q.pop_front());
        end else begin
            m_we = 1'b0;
        end
        if (m_prio_mem) begin
            if (macc && me.a != 0) q.push_back(me);
            if (aacc && ae.a != 0) q.push_back(ae);
        end else begin
            if (aacc && ae.a != 0) q.push_back(ae);
            if (macc && me.a != 0) q.push_back(me);
        end
        if (tog) m_prio_mem = ~m_prio_mem;
    endtask

    task automatic check_all();
        logic          h;
        logic [RW-1:0] d;
        chk("alu_ready", 64'(wb.alu_ready), 64'(m_alu_ready()));
        chk("mem_ready", 64'(wb.mem_ready), 64'(m_mem_ready()));
        chk("write_enable", 64'(write_enable), 64'(m_we));
        chk("write_addr", 64'(write_addr), 64'(m_wa));
        chk("write_data", 64'(write_data), 64'(m_wd));
        chk("pending_count", 64'(pending_count), 64'(q.size()));
        chk("idle", 64'(idle), 64'(q.size() == 0 && !m_we));
        m_fwd(fwd_addr_0, h, d);
        chk("fwd_hit_0", 64'(fwd_hit_0), 64'(h));
        chk("fwd_data_0", 64'(fwd_data_0), 64'(d));
        m_fwd(fwd_addr_1, h, d);
        chk("fwd_hit_1", 64'(fwd_hit_1), 64'(h));
        chk("fwd_data_1", 64'(fwd_data_1), 64'(d));
    endtask

    task automatic step(input bit av, input int aa, input logic [RW-1:0] ad,
                        input bit mv, input int ma, input logic [RW-1:0] md,
                        input int f0, input int f1);
        wb.alu_valid = av;
        wb.alu_addr  = AW'(aa);
        wb.alu_data  = ad;
        wb.mem_valid = mv;
        wb.mem_addr  = AW'(ma);
        wb.mem_data  = md;
        fwd_addr_0   = AW'(f0);
        fwd_addr_1   = AW'(f1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step(input int f0, input int f1);
        step(0, 0, '0, 0, 0, '0, f0, f1);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        fwd_addr_0   = '0;
        fwd_addr_1   = '0;
        model_reset();
        @(negedge clk);
        chk("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
        chk("rst_mem_ready", 64'(wb.mem_ready), 64'd0);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_count", 64'(pending_count), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        wb.alu_addr = '0;
        wb.alu_data = '0;
        wb.mem_addr = '0;
        wb.mem_data = '0;
        do_reset();

        // Single ALU write and its one-cycle pulse
        step(1, 1, 32'hDEADBEEF, 0, 0, '0, 1, 0);
        idle_step(1, 0);
        chk("alu_we", 64'(write_enable), 64'd1);
        chk("alu_waddr", 64'(write_addr), 64'd1);
        chk("alu_wdata", 64'(write_data), 64'hDEADBEEF);
        idle_step(1, 0);
        chk("alu_we_off", 64'(write_enable), 64'd0);
        chk("alu_idle", 64'(idle), 64'd1);

        // Load to register zero is swallowed
        chk("zero_mem_ready", 64'(wb.mem_ready), 64'd1);
        step(0, 0, '0, 1, 0, 32'h12345678, 0, 0);
        chk("zero_count", 64'(pending_count), 64'd0);
        idle_step(0, 0);
        chk("zero_no_we", 64'(write_enable), 64'd0);
        chk("zero_fwd_hit", 64'(fwd_hit_0), 64'd0);

        // Contested cycle from reset, then priority flips to MEM
        do_reset();
        step(1, 3, 32'hA0000003, 1, 4, 32'hB0000004, 3, 4);
        idle_step(3, 4);
        chk("pair_first", 64'(write_addr), 64'd3);
        chk("pair_first_d", 64'(write_data), 64'hA0000003);
        idle_step(3, 4);
        chk("pair_second", 64'(write_addr), 64'd4);
        chk("pair_second_d", 64'(write_data), 64'hB0000004);
        step(1, 5, 32'hA0000005, 1, 6, 32'hB0000006, 5, 6);
        idle_step(5, 6);
        chk("mem_prio_first", 64'(write_addr), 64'd6);
        idle_step(5, 6);
        chk("mem_prio_second", 64'(write_addr), 64'd5);
        idle_step(0, 0);

        // Continuous contention throttles readies
        for (int i = 0; i < 12; i++) begin
            step(1, 2 * i + 1, $urandom, 1, 2 * i + 2, $urandom,
                 2 * i + 1, 2 * i);
            chk("count_bound", 64'(pending_count <= 3'(D)), 64'd1);
        end
        for (int i = 0; i < 5; i++) idle_step(21, 22);
        chk("drain_idle", 64'(idle), 64'd1);

        // Same destination from both channels: youngest wins forwarding
        do_reset();
        step(1, 31, 32'hAABBCCDD, 1, 31, 32'h11111111, 0, 31);
        chk("dup_hit", 64'(fwd_hit_1), 64'd1);
        chk("dup_data", 64'(fwd_data_1), 64'h11111111);
        idle_step(0, 31);
        idle_step(0, 31);
        idle_step(0, 31);
        chk("dup_drained", 64'(fwd_hit_1), 64'd0);

        // Asynchronous reset with entries pending
        step(1, 7, 32'h70, 1, 8, 32'h80, 7, 8);
        step(1, 9, 32'h90, 1, 10, 32'hA0, 7, 8);
        chk("pre_rst_count", 64'(pending_count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(write_enable), 64'd0);
        chk("arst_count", 64'(pending_count), 64'd0);
        chk("arst_idle", 64'(idle), 64'd1);
        chk("arst_ready", 64'({wb.alu_ready, wb.mem_ready}), 64'd0);
        chk("arst_fwd", 64'(fwd_hit_0), 64'd0);
        model_reset();
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle_step(7, 9);
            chk("post_rst_no_we", 64'(write_enable), 64'd0);
        end

        // Randomized traffic over a small address set to force collisions
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 7), $urandom_range(0, 7));
        end
        for (int i = 0; i < 6; i++) idle_step(1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
